// File: rtl/tomasulo_exe_mul_pipe.sv
// ----------------------------------------------------------------------------
// tomasulo_exe_mul_pipe
//
// Multiply execution unit for a Tomasulo-style core. Each issue is multiplied
// and carried down a fixed-length, never-stalling pipeline of LATENCY_N-1
// register stages. The pipeline feeds an in-order result FIFO that drives the
// common data bus (CDB). Issue back-pressure uses a credit counter. The counter
// counts everything accepted but not yet popped, so the FIFO can never
// overflow, even though the pipeline itself cannot stall.
//
// Optional feature macro: TOMASULO_EXE_MUL_PIPE_HIGH_EN
//   defined   : iss_op selects MUL / MULH / MULHU / MULHSU
//   undefined : iss_op is ignored; every issue returns the low-word product
//
// Parameters
//   W         operand/result width
//   TAG_W     reservation-station tag width
//   LATENCY_N accept-to-result latency in cycles (2..8)
//   OUT_Q_N   result FIFO depth, which is also the credit limit (>=1)
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   iss_vld/iss_rdy    issue handshake; iss_tag/iss_a/iss_b/iss_op payload
//   flush              discards all in-flight and queued work
//   cdb_vld/cdb_gnt    result valid / CDB grant (pop when both are high)
//   cdb_tag/cdb_data   FIFO head; driven to zero when cdb_vld is low
// ----------------------------------------------------------------------------
module tomasulo_exe_mul_pipe #(
   parameter int W         = 32,
   parameter int TAG_W     = 4,
   parameter int LATENCY_N = 5,
   parameter int OUT_Q_N   = LATENCY_N + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             iss_vld,
   output logic             iss_rdy,
   input  logic [TAG_W-1:0] iss_tag,
   input  logic [W-1:0]     iss_a,
   input  logic [W-1:0]     iss_b,
   input  logic [1:0]       iss_op,
   input  logic             flush,
   output logic             cdb_vld,
   input  logic             cdb_gnt,
   output logic [TAG_W-1:0] cdb_tag,
   output logic [W-1:0]     cdb_data
);

   localparam int STG = LATENCY_N - 1;
   localparam int PW  = (OUT_Q_N > 1) ? $clog2(OUT_Q_N) : 1;
   localparam int CW  = $clog2(OUT_Q_N + 1);
   localparam logic [CW-1:0] Q_FULL = CW'(OUT_Q_N);

   logic             r_stg_vld  [STG];
   logic [TAG_W-1:0] r_stg_tag  [STG];
   logic [W-1:0]     r_stg_data [STG];

   logic [TAG_W-1:0] r_q_tag  [OUT_Q_N];
   logic [W-1:0]     r_q_data [OUT_Q_N];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_q_cnt;
   logic [CW-1:0]    r_cnt;

   logic             w_acc;
   logic             w_pop;
   logic             w_push;
   logic [W-1:0]     w_prod;

   // ---------------------------------------------------------------- product
`ifdef TOMASULO_EXE_MUL_PIPE_HIGH_EN
   logic                  w_a_sgn;
   logic                  w_b_sgn;
   logic signed [W:0]     w_a_ext;
   logic signed [W:0]     w_b_ext;
   logic signed [2*W+1:0] w_full;
   logic [1:0]            w_unused_ext;

   // One extra bit on each operand lets a single signed multiplier cover
   // all three signedness combinations.
   assign w_a_sgn      = (iss_op == 2'd1) || (iss_op == 2'd3);
   assign w_b_sgn      = (iss_op == 2'd1);
   assign w_a_ext      = {w_a_sgn & iss_a[W-1], iss_a};
   assign w_b_ext      = {w_b_sgn & iss_b[W-1], iss_b};
   assign w_full       = w_a_ext * w_b_ext;
   assign w_unused_ext = w_full[2*W+1:2*W];
   assign w_prod       = (iss_op == 2'd0) ? w_full[W-1:0] : w_full[2*W-1:W];
`else
   logic w_unused_op;

   assign w_unused_op = ^iss_op;
   assign w_prod      = iss_a * iss_b;
`endif

   // -------------------------------------------------------------- handshake
   assign iss_rdy  = (r_cnt < Q_FULL) && !rst;
   assign w_acc    = iss_vld && iss_rdy && !flush;
   assign cdb_vld  = (r_q_cnt != '0) && !rst;
   assign w_pop    = cdb_vld && cdb_gnt && !flush;
   assign w_push   = r_stg_vld[STG-1];
   assign cdb_tag  = cdb_vld ? r_q_tag[r_rd_ptr]  : '0;
   assign cdb_data = cdb_vld ? r_q_data[r_rd_ptr] : '0;

   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == PW'(OUT_Q_N - 1)) ? '0 : p + 1'b1;
   endfunction

   // --------------------------------------------------------------- pipeline
   // Payload registers shift every cycle. Only the valid bits carry meaning,
   // so only the valid bits are reset.
   always_ff @(posedge clk) begin
      r_stg_tag[0]  <= iss_tag;
      r_stg_data[0] <= w_prod;
      for (int i = 1; i < STG; i++) begin
         r_stg_tag[i]  <= r_stg_tag[i-1];
         r_stg_data[i] <= r_stg_data[i-1];
      end
      if (rst || flush) begin
         for (int i = 0; i < STG; i++) r_stg_vld[i] <= 1'b0;
      end else begin
         r_stg_vld[0] <= w_acc;
         for (int i = 1; i < STG; i++) r_stg_vld[i] <= r_stg_vld[i-1];
      end
   end

   // ------------------------------------------------------ result FIFO/credit
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_tag[r_wr_ptr]  <= r_stg_tag[STG-1];
         r_q_data[r_wr_ptr] <= r_stg_data[STG-1];
      end
      if (rst || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_q_cnt  <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) r_wr_ptr <= f_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_q_cnt <= r_q_cnt + 1'b1;
            2'b01:   r_q_cnt <= r_q_cnt - 1'b1;
            default: r_q_cnt <= r_q_cnt;
         endcase
         case ({w_acc, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule
